commit_tracker: RTL and testbench
=================================

# commit_tracker

Writeback-side counterpart to the issue-stage data-hazard scoreboard. Tracks every issued instruction through the EX, MEM and WB slots and holds a pending-write vector for the hazard check. Generates the register-file write strobe and releases each pending destination when its writer retires. Handles load stalls via a memory acknowledge, and flushes on branch-taken or exception.

## Interface
Parameters:
- NREG, 32, architectural registers; register address width is 5 bits.
- CNTW, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- issue_valid  in  1  an instruction is offered for issue this cycle.
- issue_rd  in  5  destination register of the offered instruction.
- issue_wb  in  1  offered instruction writes rd (lui/auipc/jal/ALU/load/CSR).
- issue_load  in  1  offered instruction is a load.
- issue_ready  out  1  EX slot can accept an instruction this cycle.
- mem_ack  in  1  load data returned for the load held in MEM.
- flush  in  1  kill all instructions in EX and MEM.
- mem_stall  out  1  a load in MEM is waiting for mem_ack.
- pending  out  NREG  bit r set while any valid in-flight writer targets r (r≠0).
- rf_we  out  1  register-file write enable for the WB entry.
- rf_waddr  out  5  register-file write address.
- retired  out  CNTW  count of instructions that left WB.

## Operation
- Three slots: EX, MEM, WB. Each slot holds valid, rd, wb and load.
- Every edge, WB drains unconditionally. A valid WB entry counts as retired, whether it writes or not.
- MEM moves to WB when MEM holds no load, or when mem_ack is high. A load held in MEM without mem_ack stays in MEM, and WB receives a bubble.
- EX moves to MEM when MEM is empty or MEM is moving. Otherwise EX holds.
- issue_ready = !EX.valid || EX moving, computed combinationally. The instruction is captured into EX when issue_valid && issue_ready && !flush.
- mem_stall = MEM.valid && MEM.load && !mem_ack.
- pending is a combinational OR over the three slots of the one-hot decode of rd, gated by valid && wb && rd≠0. Bit 0 is always 0.
  - A register targeted by two in-flight writers stays set until the younger one retires.
- rf_we = WB.valid && WB.wb && WB.rd≠0. rf_waddr = WB.rd when rf_we is high, otherwise 0.
- Flush: EX.valid and MEM.valid clear at the edge, and any issue in that cycle is dropped. The WB slot still retires normally.
  - If a held load is flushed, mem_ack on a later cycle is ignored.
  - An EX→MEM or MEM→WB transfer in the flush cycle is also suppressed; WB receives a bubble.
- retired increments by 1 per valid WB entry and wraps modulo 2^CNTW.

## Timing
- Reset (async, immediate): all slot valid bits clear and retired = 0.
- Output values during reset: issue_ready = 1, mem_stall = 0, pending = 0, rf_we = 0, rf_waddr = 0.
- Non-load latency: issue accepted at edge k. The entry sits in EX after k, in MEM after k+1 and in WB after k+2. rf_we is high for the cycle following k+2. The pending bit is set from just after edge k until edge k+3.
- Load latency: the load reaches MEM after edge k+1. It moves to WB at the first edge where mem_ack is sampled high. rf_we is high for the following cycle.
  - mem_ack already high in the cycle after k+1 gives the same latency as a non-load.
- Back-pressure: while a load stalls, an entry behind it holds in EX and issue_ready = 0. issue_ready returns to 1 combinationally in the cycle in which mem_ack is high.
- mem_ack while MEM holds no load, or holds a non-load, is ignored.
- Full throughput: one issue per cycle, one retirement per cycle, no bubbles without stalls.

## Test plan
- Reset, then issue ALU rd=5 at edge 1 -> pending[5]=1 after edge 1. rf_we=1 with rf_waddr=5 after edge 3. pending[5]=0 and retired=1 after edge 4.
- Load rd=7 followed by ALU rd=8, mem_ack withheld 4 cycles -> mem_stall=1 and issue_ready=0 for 4 cycles. pending[7] and pending[8] stay set. Load writes back first, then ALU. retired=2 at the end.
- Back-to-back ALU writes to x3 then x3 -> pending[3] stays high until the second retires, exactly one cycle after the first write.
- Flush while a load rd=9 is stalled and ALU rd=4 is in EX -> both dropped at the edge, pending=0 afterwards except the WB entry. A later mem_ack is ignored, and retired does not count the dropped entries.
- Issue to rd=0 with wb=1 -> pending[0]=0 throughout, rf_we=0, retired still increments.
- Async reset asserted mid-stall -> all outputs at reset values immediately. Preload retired to 0xFFFF and retire one more -> wraps to 0.

Source files
------------

// File: rtl/commit_if.sv
// Issue/writeback handshake bundle between the issue stage and commit_tracker.
// The master side offers instructions and memory acks; the slave side reports hazards and writeback.
interface commit_if #(
    parameter int NREG = 32,
    parameter int CNTW = 16
);
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_wb;
    logic            issue_load;
    logic            issue_ready;
    logic            mem_ack;
    logic            flush;
    logic            mem_stall;
    logic [NREG-1:0] pending;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [CNTW-1:0] retired;

    modport master (
        output issue_valid, issue_rd, issue_wb, issue_load, mem_ack, flush,
        input  issue_ready, mem_stall, pending, rf_we, rf_waddr, retired
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wb, issue_load, mem_ack, flush,
        output issue_ready, mem_stall, pending, rf_we, rf_waddr, retired
    );
endinterface

// File: rtl/commit_tracker.sv
// Tracks in-flight instructions through EX/MEM/WB, publishes the pending-write vector
// for the hazard check, drives the register-file write strobe and counts retirements.
module commit_tracker #(
    parameter int NREG = 32,
    parameter int CNTW = 16
) (
    input logic      clk,
    input logic      rst,
    commit_if.slave  bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wb;
        logic       load;
    } slot_t;

    slot_t           ex_q, mem_q, wb_q;
    slot_t           ex_d, mem_d, wb_d;
    logic            mem_move;
    logic            ex_move;
    logic            issue_fire;
    logic [CNTW-1:0] retired_q;

    // One-hot destination of a slot that will write a real register.
    function automatic logic [NREG-1:0] slot_mask(input slot_t s);
        logic [NREG-1:0] m;
        m = '0;
        if (s.valid && s.wb && (s.rd != 5'd0))
            m[s.rd] = 1'b1;
        return m;
    endfunction

    assign mem_move   = mem_q.valid && (!mem_q.load || bus.mem_ack);
    assign ex_move    = ex_q.valid && (!mem_q.valid || mem_move);
    assign issue_fire = bus.issue_valid && bus.issue_ready && !bus.flush;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = mem_q;

        // Flush kills EX and MEM and turns any transfer into a bubble; WB still retires.
        wb_d.valid = mem_move && !bus.flush;

        if (bus.flush)
            mem_d.valid = 1'b0;
        else if (ex_move)
            mem_d = ex_q;
        else if (mem_move)
            mem_d.valid = 1'b0;

        if (bus.flush) begin
            ex_d.valid = 1'b0;
        end else if (issue_fire) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = bus.issue_rd;
            ex_d.wb    = bus.issue_wb;
            ex_d.load  = bus.issue_load;
        end else if (ex_move) begin
            ex_d.valid = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all slots update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            retired_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            if (wb_q.valid)
                retired_q <= retired_q + CNTW'(1);
        end
    end

    assign bus.issue_ready = !ex_q.valid || ex_move;
    assign bus.mem_stall   = mem_q.valid && mem_q.load && !bus.mem_ack;
    assign bus.pending     = slot_mask(ex_q) | slot_mask(mem_q) | slot_mask(wb_q);
    assign bus.rf_we       = wb_q.valid && wb_q.wb && (wb_q.rd != 5'd0);
    assign bus.rf_waddr    = bus.rf_we ? wb_q.rd : 5'd0;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_commit_tracker.sv
// Directed bench for commit_tracker: latency, load stall, hazards, flush, rd=0, reset and wrap.
module tb_commit_tracker;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    commit_if #(.NREG(32), .CNTW(16)) bus ();
    commit_if #(.NREG(32), .CNTW(4))  bus_w ();

    commit_tracker #(.NREG(32), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow counter instance so the wrap can be reached in a few cycles.
    commit_tracker #(.NREG(32), .CNTW(4)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic v, input logic [4:0] rd, input logic wb, input logic ld);
        bus.issue_valid = v;
        bus.issue_rd    = rd;
        bus.issue_wb    = wb;
        bus.issue_load  = ld;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_issue(1'b0, 5'd0, 1'b0, 1'b0);
        bus.mem_ack = 1'b0;
        bus.flush   = 1'b0;
        bus_w.issue_valid = 1'b0;
        bus_w.issue_rd    = 5'd0;
        bus_w.issue_wb    = 1'b0;
        bus_w.issue_load  = 1'b0;
        bus_w.mem_ack     = 1'b0;
        bus_w.flush       = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_issue(1'b0, 5'd0, 1'b0, 1'b0);
        bus.mem_ack = 1'b0;
        bus.flush   = 1'b0;
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus.issue_ready); end
        checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", bus.mem_stall); end
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %0h want 0", bus.pending); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b want 0", bus.rf_we); end
        checks++; if (bus.retired !== 16'h0) begin errors++; $display("FAIL reset_retired: got %0h want 0", bus.retired); end
    endtask

    task automatic test_alu_latency();
        do_reset();
        drive_issue(1'b1, 5'd5, 1'b1, 1'b0);
        step(); // edge 1
        drive_issue(1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (bus.pending !== 32'h0000_0020) begin errors++; $display("FAIL alu_pending_e1: got %0h want 20", bus.pending); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL alu_we_e1: got %0b want 0", bus.rf_we); end
        step(); // edge 2
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL alu_we_e2: got %0b want 0", bus.rf_we); end
        step(); // edge 3
        checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL alu_we_e3: got %0b want 1", bus.rf_we); end
        checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr_e3: got %0d want 5", bus.rf_waddr); end
        checks++; if (bus.pending[5] !== 1'b1) begin errors++; $display("FAIL alu_pend_e3: got %0b want 1", bus.pending[5]); end
        checks++; if (bus.retired !== 16'd0) begin errors++; $display("FAIL alu_ret_e3: got %0d want 0", bus.retired); end
        step(); // edge 4
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL alu_pending_e4: got %0h want 0", bus.pending); end
        checks++; if (bus.retired !== 16'd1) begin errors++; $display("FAIL alu_ret_e4: got %0d want 1", bus.retired); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL alu_we_e4: got %0b want 0", bus.rf_we); end
    endtask

    task automatic test_load_stall();
        do_reset();
        drive_issue(1'b1, 5'd7, 1'b1, 1'b1);
        step(); // edge 1: load in EX
        drive_issue(1'b1, 5'd8, 1'b1, 1'b0);
        step(); // edge 2: load in MEM, ALU in EX
        drive_issue(1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.mem_stall !== 1'b1) begin errors++; $display("FAIL ld_stall_%0d: got %0b want 1", i, bus.mem_stall); end
            checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_%0d: got %0b want 0", i, bus.issue_ready); end
            checks++; if (bus.pending !== 32'h0000_0180) begin errors++; $display("FAIL ld_pending_%0d: got %0h want 180", i, bus.pending); end
            checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL ld_we_%0d: got %0b want 0", i, bus.rf_we); end
            if (i < 3) step();
        end
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL ld_ready_ack: got %0b want 1", bus.issue_ready); end
        checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL ld_stall_ack: got %0b want 0", bus.mem_stall); end
        step(); // load to WB, ALU to MEM
        bus.mem_ack = 1'b0;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7) begin errors++; $display("FAIL ld_wb_load: got we=%0b addr=%0d want we=1 addr=7", bus.rf_we, bus.rf_waddr); end
        step();
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd8) begin errors++; $display("FAIL ld_wb_alu: got we=%0b addr=%0d want we=1 addr=8", bus.rf_we, bus.rf_waddr); end
        checks++; if (bus.retired !== 16'd1) begin errors++; $display("FAIL ld_ret_mid: got %0d want 1", bus.retired); end
        step();
        checks++; if (bus.retired !== 16'd2) begin errors++; $display("FAIL ld_ret_end: got %0d want 2", bus.retired); end
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL ld_pending_end: got %0h want 0", bus.pending); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_issue(1'b1, 5'd3, 1'b1, 1'b0);
        step(); // edge 1
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b want 1", bus.issue_ready); end
        step(); // edge 2
        drive_issue(1'b0, 5'd0, 1'b0, 1'b0);
        step(); // edge 3
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3) begin errors++; $display("FAIL b2b_wr1: got we=%0b addr=%0d want we=1 addr=3", bus.rf_we, bus.rf_waddr); end
        checks++; if (bus.pending !== 32'h0000_0008) begin errors++; $display("FAIL b2b_pend_e3: got %0h want 8", bus.pending); end
        step(); // edge 4
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3) begin errors++; $display("FAIL b2b_wr2: got we=%0b addr=%0d want we=1 addr=3", bus.rf_we, bus.rf_waddr); end
        checks++; if (bus.pending !== 32'h0000_0008) begin errors++; $display("FAIL b2b_pend_e4: got %0h want 8", bus.pending); end
        checks++; if (bus.retired !== 16'd1) begin errors++; $display("FAIL b2b_ret_e4: got %0d want 1", bus.retired); end
        step(); // edge 5
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL b2b_pend_e5: got %0h want 0", bus.pending); end
        checks++; if (bus.retired !== 16'd2) begin errors++; $display("FAIL b2b_ret_e5: got %0d want 2", bus.retired); end
    endtask

    task automatic test_flush();
        do_reset();
        drive_issue(1'b1, 5'd2, 1'b1, 1'b0);
        step(); // edge 1
        drive_issue(1'b1, 5'd9, 1'b1, 1'b1);
        step(); // edge 2
        drive_issue(1'b1, 5'd4, 1'b1, 1'b0);
        step(); // edge 3: WB=x2, MEM=load x9 (stalled), EX=x4
        drive_issue(1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (bus.pending !== 32'h0000_0214) begin errors++; $display("FAIL fl_pend_pre: got %0h want 214", bus.pending); end
        checks++; if (bus.mem_stall !== 1'b1) begin errors++; $display("FAIL fl_stall_pre: got %0b want 1", bus.mem_stall); end
        bus.flush = 1'b1;
        drive_issue(1'b1, 5'd6, 1'b1, 1'b0);
        step(); // edge 4: flush
        bus.flush = 1'b0;
        drive_issue(1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL fl_pend_post: got %0h want 0", bus.pending); end
        checks++; if (bus.retired !== 16'd1) begin errors++; $display("FAIL fl_ret_post: got %0d want 1", bus.retired); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL fl_we_post: got %0b want 0", bus.rf_we); end
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL fl_stall_ack: got %0b want 0", bus.mem_stall); end
        step();
        bus.mem_ack = 1'b0;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL fl_we_ack: got %0b want 0", bus.rf_we); end
        step();
        step();
        checks++; if (bus.retired !== 16'd1) begin errors++; $display("FAIL fl_ret_late: got %0d want 1", bus.retired); end
        // Issue offered with EX free but flush high must be dropped.
        drive_issue(1'b1, 5'd6, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL fl_drop_ready: got %0b want 1", bus.issue_ready); end
        step();
        bus.flush = 1'b0;
        drive_issue(1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL fl_drop_pend: got %0h want 0", bus.pending); end
        step();
        step();
        step();
        checks++; if (bus.retired !== 16'd1) begin errors++; $display("FAIL fl_drop_ret: got %0d want 1", bus.retired); end
    endtask

    task automatic test_rd_zero();
        do_reset();
        drive_issue(1'b1, 5'd0, 1'b1, 1'b0);
        step(); // edge 1
        drive_issue(1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL rd0_pend_e%0d: got %0h want 0", i, bus.pending); end
            checks++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL rd0_we_e%0d: got we=%0b addr=%0d want 0/0", i, bus.rf_we, bus.rf_waddr); end
            step();
        end
        checks++; if (bus.retired !== 16'd1) begin errors++; $display("FAIL rd0_ret: got %0d want 1", bus.retired); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_issue(1'b1, 5'd1, 1'b1, 1'b0);
        step(); // edge 1
        drive_issue(1'b1, 5'd7, 1'b1, 1'b1);
        step(); // edge 2
        drive_issue(1'b1, 5'd8, 1'b1, 1'b0);
        step(); // edge 3
        drive_issue(1'b0, 5'd0, 1'b0, 1'b0);
        step(); // edge 4: x1 retired, load stalled in MEM, x8 held in EX
        checks++; if (bus.retired !== 16'd1 || bus.mem_stall !== 1'b1) begin errors++; $display("FAIL ar_pre: got ret=%0d stall=%0b want 1/1", bus.retired, bus.mem_stall); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %0b want 1", bus.issue_ready); end
        checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL ar_stall: got %0b want 0", bus.mem_stall); end
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL ar_pending: got %0h want 0", bus.pending); end
        checks++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL ar_rf: got we=%0b addr=%0d want 0/0", bus.rf_we, bus.rf_waddr); end
        checks++; if (bus.retired !== 16'd0) begin errors++; $display("FAIL ar_retired: got %0d want 0", bus.retired); end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        bus_w.issue_valid = 1'b1;
        bus_w.issue_rd    = 5'd1;
        bus_w.issue_wb    = 1'b1;
        for (int i = 0; i < 16; i++) step(); // issues at edges 1..16
        bus_w.issue_valid = 1'b0;
        step();
        step(); // edge 18: 15 retired
        checks++; if (bus_w.retired !== 4'hF) begin errors++; $display("FAIL wrap_max: got %0h want f", bus_w.retired); end
        step(); // edge 19: 16 retired
        checks++; if (bus_w.retired !== 4'h0) begin errors++; $display("FAIL wrap_zero: got %0h want 0", bus_w.retired); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_alu_latency();
        test_load_stall();
        test_back_to_back();
        test_flush();
        test_rd_zero();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
